// File: rtl/openmips_min_sopc_if.sv
`default_nettype none
// ============================================================================
// Module  : openmips_min_sopc_if
// Purpose : Fetch and data-memory bus between the core and its memories.
// Rev     : 1.0 - initial release
// ============================================================================
interface openmips_min_sopc_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  sel;    // sel[3] = byte offset 0 (bank3) ... sel[0] = offset 3 (bank0)
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output pc, input inst, output addr, output we, output sel,
                  output wdata, input rdata);
  modport slave  (input pc, output inst, input addr, input we, input sel,
                  input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/openmips_min_sopc.sv
`default_nettype none
// ============================================================================
// Module  : openmips_min_sopc
// Purpose : Single-cycle MIPS32 subset core with instruction ROM and data RAM.
//           Define OPENMIPS_UNALIGNED_LS_EN to enable lwl/lwr/swl/swr.
// Rev     : 1.0 - initial release
// ============================================================================

module regfile (
  input  wire        clk,
  input  wire        we,
  input  wire [4:0]  waddr,
  input  wire [31:0] wdata,
  input  wire [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  wire [4:0]  raddr2,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // regs[0] is held at zero so the array always shows the architectural value
  always_ff @(posedge clk) begin
    regs[0] <= '0;
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module inst_rom #(
  parameter int WORDS = 1024
) (
  openmips_min_sopc_if.slave bus
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0]   inst_mem [0:WORDS-1];
  logic [AW-1:0] idx;

  assign idx      = AW'(bus.pc[31:2] % 30'(WORDS));
  assign bus.inst = inst_mem[idx];
endmodule

module data_ram #(
  parameter int WORDS = 1024
) (
  input wire clk,
  openmips_min_sopc_if.slave bus
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [7:0]    bank0 [0:WORDS-1];
  logic [7:0]    bank1 [0:WORDS-1];
  logic [7:0]    bank2 [0:WORDS-1];
  logic [7:0]    bank3 [0:WORDS-1];
  logic [AW-1:0] idx;

  assign idx       = AW'(bus.addr[31:2] % 30'(WORDS));
  assign bus.rdata = {bank3[idx], bank2[idx], bank1[idx], bank0[idx]};

  always_ff @(posedge clk) begin
    if (bus.we) begin
      if (bus.sel[3]) bank3[idx] <= bus.wdata[31:24];
      if (bus.sel[2]) bank2[idx] <= bus.wdata[23:16];
      if (bus.sel[1]) bank1[idx] <= bus.wdata[15:8];
      if (bus.sel[0]) bank0[idx] <= bus.wdata[7:0];
    end
  end
endmodule

module openmips (
  input wire clk,
  input wire rst,
  openmips_min_sopc_if.master bus
);
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;
  localparam logic [5:0] FN_OR      = 6'h25;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [5:0]  op, funct;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v;
  logic [1:0]  n;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wd;
  logic        unused_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= pc + 32'd4;
  end

  assign bus.pc = pc;
  assign inst   = rst ? '0 : bus.inst;
  assign op     = inst[31:26];
  assign rs_a   = inst[25:21];
  assign rt_a   = inst[20:16];
  assign rd_a   = inst[15:11];
  assign imm    = inst[15:0];
  assign funct  = inst[5:0];
  assign unused_shamt = ^inst[10:6];

  regfile regfile1 (
    .clk    (clk),
    .we     (reg_we),
    .waddr  (reg_wa),
    .wdata  (reg_wd),
    .raddr1 (rs_a),
    .rdata1 (rs_v),
    .raddr2 (rt_a),
    .rdata2 (rt_v)
  );

  assign bus.addr  = rs_v + {{16{imm[15]}}, imm};
  assign n         = bus.addr[1:0];
  // big-endian: byte offset n sits 8*(3-n) bits up from the LSB
  assign lbyte     = 8'(bus.rdata >> {~n, 3'b000});
  assign lhalf     = bus.addr[1] ? bus.rdata[15:0] : bus.rdata[31:16];
  assign bus.we    = mem_we;
  assign bus.sel   = mem_sel;
  assign bus.wdata = mem_wd;

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rt_a;
    reg_wd  = '0;
    mem_we  = 1'b0;
    mem_sel = 4'b0000;
    mem_wd  = rt_v;
    if (!rst) begin
      case (op)
        OP_SPECIAL: if (funct == FN_OR) begin
          reg_we = 1'b1; reg_wa = rd_a; reg_wd = rs_v | rt_v;
        end
        OP_ORI: begin reg_we = 1'b1; reg_wd = rs_v | {16'h0000, imm}; end
        OP_LUI: begin reg_we = 1'b1; reg_wd = {imm, 16'h0000}; end
        OP_LB:  begin reg_we = 1'b1; reg_wd = {{24{lbyte[7]}}, lbyte}; end
        OP_LBU: begin reg_we = 1'b1; reg_wd = {24'h0, lbyte}; end
        OP_LH:  begin reg_we = 1'b1; reg_wd = {{16{lhalf[15]}}, lhalf}; end
        OP_LHU: begin reg_we = 1'b1; reg_wd = {16'h0, lhalf}; end
        OP_LW:  begin reg_we = 1'b1; reg_wd = bus.rdata; end
        OP_SB: begin
          mem_we = 1'b1; mem_sel = 4'b1000 >> n; mem_wd = {4{rt_v[7:0]}};
        end
        OP_SH: begin
          mem_we = 1'b1; mem_sel = bus.addr[1] ? 4'b0011 : 4'b1100;
          mem_wd = {2{rt_v[15:0]}};
        end
        OP_SW: begin mem_we = 1'b1; mem_sel = 4'b1111; end
`ifdef OPENMIPS_UNALIGNED_LS_EN
        OP_LWL: begin
          reg_we = 1'b1;
          reg_wd = (bus.rdata << {n, 3'b000}) | (rt_v & ~(32'hFFFF_FFFF << {n, 3'b000}));
        end
        OP_LWR: begin
          // a shift of 32 (n=3) clears the keep-mask entirely
          reg_we = 1'b1;
          reg_wd = (bus.rdata >> {~n, 3'b000})
                 | (rt_v & (32'hFFFF_FFFF << ({1'b0, n, 3'b000} + 6'd8)));
        end
        OP_SWL: begin
          mem_we = 1'b1; mem_sel = 4'b1111 >> n; mem_wd = rt_v >> {n, 3'b000};
        end
        OP_SWR: begin
          mem_we = 1'b1; mem_sel = 4'b1111 << ~n; mem_wd = rt_v << {~n, 3'b000};
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

module openmips_min_sopc #(
  parameter int INST_ROM_WORDS = 1024,
  parameter int DATA_RAM_WORDS = 1024
) (
  input wire clk,
  input wire rst
);
  openmips_min_sopc_if bus ();

  openmips openmips0 (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  inst_rom #(.WORDS(INST_ROM_WORDS)) inst_rom0 (
    .bus (bus)
  );

  data_ram #(.WORDS(DATA_RAM_WORDS)) data_ram0 (
    .clk (clk),
    .bus (bus)
  );
endmodule
`default_nettype wire

// File: tb/tb_openmips_min_sopc.sv
`default_nettype none
// ============================================================================
// Module  : tb_openmips_min_sopc
// Purpose : Scoreboarded random-program bench for openmips_min_sopc.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_openmips_min_sopc;
  localparam int ROMW = 1024;
  localparam int RAMW = 1024;
  localparam int MEMB = RAMW * 4;
  localparam int L1   = 168;
  localparam int L2   = 40;

  typedef struct {
    logic [31:0] pc;
    int          ridx;
    logic [31:0] rval;
    int          waddr;
    logic [31:0] wval;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] mreg [32];
  logic [7:0]  mmem [MEMB];
  logic [31:0] rom_img [ROMW];
  logic [31:0] mpc;
  exp_t        sb_q [$];

  openmips_min_sopc_if tap ();

  openmips_min_sopc #(.INST_ROM_WORDS(ROMW), .DATA_RAM_WORDS(RAMW)) dut (
    .clk (clk),
    .rst (rst)
  );

  assign tap.pc    = dut.bus.pc;
  assign tap.inst  = dut.bus.inst;
  assign tap.addr  = dut.bus.addr;
  assign tap.we    = dut.bus.we;
  assign tap.sel   = dut.bus.sel;
  assign tap.wdata = dut.bus.wdata;
  assign tap.rdata = dut.bus.rdata;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return int'(a % 32'(MEMB));
  endfunction

  function automatic logic [31:0] mword(input int b);
    return {mmem[b], mmem[b+1], mmem[b+2], mmem[b+3]};
  endfunction

  function automatic logic [31:0] ram_word(input int b);
    int w;
    w = b / 4;
    return {dut.data_ram0.bank3[w], dut.data_ram0.bank2[w],
            dut.data_ram0.bank1[w], dut.data_ram0.bank0[w]};
  endfunction

  // byte j of a word counted from the most significant end
  function automatic logic [7:0] getbyte(input logic [31:0] v, input int j);
    return 8'(v >> (8 * (3 - j)));
  endfunction

  function automatic logic [31:0] setbyte(input logic [31:0] v, input int j, input logic [7:0] b);
    int sh;
    sh = 8 * (3 - j);
    return (v & ~(32'hFF << sh)) | (32'(b) << sh);
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input int s);
    logic [31:0] base, v;
    base = a - (a % 32'(s));
    v = '0;
    for (int i = 0; i < s; i++) v = (v << 8) | 32'(mmem[bidx(base + 32'(i))]);
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input int s, input logic [31:0] val);
    logic [31:0] base;
    base = a - (a % 32'(s));
    for (int i = 0; i < s; i++) mmem[bidx(base + 32'(i))] = 8'(val >> (8 * (s - 1 - i)));
  endtask

  task automatic model_step(output exp_t e);
    logic [31:0] ins, rsv, rtv, a, v, w;
    int op, rt, rd, fn, n, dst, st;
    ins = rom_img[(mpc >> 2) % ROMW];
    op  = int'(ins[31:26]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    fn  = int'(ins[5:0]);
    rsv = mreg[ins[25:21]];
    rtv = mreg[rt];
    a   = rsv + {{16{ins[15]}}, ins[15:0]};
    n   = int'(a % 4);
    w   = a - (a % 4);
    dst = -1;
    st  = -1;
    v   = '0;
    case (op)
      'h00: if (fn == 'h25) begin dst = rd; v = rsv | rtv; end
      'h0D: begin dst = rt; v = rsv | {16'h0, ins[15:0]}; end
      'h0F: begin dst = rt; v = 32'(ins[15:0]) * 65536; end
      'h20: begin dst = rt; v = mload(a, 1); if (v >= 128) v = v - 256; end
      'h21: begin dst = rt; v = mload(a, 2); if (v >= 32768) v = v - 65536; end
      'h23: begin dst = rt; v = mload(a, 4); end
      'h24: begin dst = rt; v = mload(a, 1); end
      'h25: begin dst = rt; v = mload(a, 2); end
      'h28: begin mstore(a, 1, rtv); st = bidx(w); end
      'h29: begin mstore(a, 2, rtv); st = bidx(w); end
      'h2B: begin mstore(a, 4, rtv); st = bidx(w); end
`ifdef OPENMIPS_UNALIGNED_LS_EN
      'h22: begin
        dst = rt; v = rtv;
        for (int j = 0; j <= 3 - n; j++) v = setbyte(v, j, mmem[bidx(w + 32'(n + j))]);
      end
      'h26: begin
        dst = rt; v = rtv;
        for (int j = 3 - n; j <= 3; j++) v = setbyte(v, j, mmem[bidx(w + 32'(j - (3 - n)))]);
      end
      'h2A: begin
        for (int j = 0; j <= 3 - n; j++) mmem[bidx(w + 32'(n + j))] = getbyte(rtv, j);
        st = bidx(w);
      end
      'h2E: begin
        for (int i = 0; i <= n; i++) mmem[bidx(w + 32'(i))] = getbyte(rtv, 3 - n + i);
        st = bidx(w);
      end
`endif
      default: ;
    endcase
    if (dst > 0) mreg[dst] = v;
    e.ridx  = (dst >= 0) ? dst : int'($urandom_range(31));
    e.rval  = mreg[e.ridx];
    e.waddr = (st >= 0) ? st : 4 * int'($urandom_range(MEMB / 4 - 1));
    e.wval  = mword(e.waddr);
    e.pc    = mpc + 32'd4;
    mpc     = mpc + 32'd4;
  endtask

  task automatic push_segment(input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      model_step(e);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int r = 1; r < 32; r++)
      check($sformatf("%s_reg%0d", tag, r), dut.openmips0.regfile1.regs[r], mreg[r]);
  endtask

  // monitor: every unreset rising edge retires one instruction
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_retire: got pc %h expected no retirement", tap.pc);
        end else begin
          e = sb_q.pop_front();
          check("pc", tap.pc, e.pc);
          check($sformatf("reg%0d@pc%0h", e.ridx, e.pc - 4), dut.openmips0.regfile1.regs[e.ridx], e.rval);
          check($sformatf("mem%0h@pc%0h", e.waddr, e.pc - 4), ram_word(e.waddr), e.wval);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned ops [17];
    int op, k;
    ops = '{'h0D, 'h0F, 'h00, 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B,
            'h22, 'h26, 'h2A, 'h2E, 'h08, 'h01};

    for (int i = 0; i < ROMW; i++) rom_img[i] = '0;
    rom_img[0]  = enc_i('h0D, 0, 3, 'hEEFF);
    rom_img[1]  = enc_i('h28, 0, 3, 3);
    rom_img[2]  = enc_i('h24, 0, 1, 3);
    rom_img[3]  = enc_i('h20, 0, 1, 3);
    rom_img[4]  = enc_i('h0D, 0, 3, 'hAABB);
    rom_img[5]  = enc_i('h29, 0, 3, 4);
    rom_img[6]  = enc_i('h21, 0, 1, 4);
    rom_img[7]  = enc_i('h25, 0, 1, 4);
    rom_img[8]  = enc_i('h0F, 0, 3, 'h4455);
    rom_img[9]  = enc_i('h0D, 3, 3, 'h6677);
    rom_img[10] = enc_i('h2B, 0, 3, 8);
    rom_img[11] = enc_i('h23, 0, 1, 8);
    rom_img[12] = enc_i('h0F, 0, 1, 'h1122);
    rom_img[13] = enc_i('h0D, 1, 1, 'h3344);
    rom_img[14] = enc_i('h22, 0, 1, 9);
    rom_img[15] = enc_i('h26, 0, 1, 10);
    rom_img[16] = enc_i('h0D, 0, 0, 'h1234);
    rom_img[17] = enc_r(0, 0, 1, 'h25);
    for (int i = 18; i < L1; i++) begin
      k  = int'($urandom_range(17));
      op = (k == 17) ? 0 : int'(ops[k]);
      if (k == 17) rom_img[i] = '0;
      else if (op == 0)
        rom_img[i] = enc_r(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
                           ($urandom_range(3) == 0) ? 'h21 : 'h25);
      else
        rom_img[i] = enc_i(op, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(16'hFFFF)));
    end
    // instruction caught in flight by the mid-program reset
    rom_img[L1] = enc_i('h0D, 0, 5, 'hBEEF);
    for (int i = 0; i < ROMW; i++) dut.inst_rom0.inst_mem[i] = rom_img[i];

    for (int i = 0; i < MEMB; i++) mmem[i] = 8'($urandom);
    for (int i = 0; i < RAMW; i++) begin
      dut.data_ram0.bank3[i] = mmem[4*i];
      dut.data_ram0.bank2[i] = mmem[4*i+1];
      dut.data_ram0.bank1[i] = mmem[4*i+2];
      dut.data_ram0.bank0[i] = mmem[4*i+3];
    end
    mreg[0] = '0;
    for (int r = 1; r < 32; r++) mreg[r] = $urandom;
    for (int r = 0; r < 32; r++) dut.openmips0.regfile1.regs[r] = mreg[r];
    mpc = '0;

    // reset held 20 ns: nothing may retire
    repeat (2) begin
      @(negedge clk);
      check("reset_pc", tap.pc, 32'h0);
      check("reset_reg3", dut.openmips0.regfile1.regs[3], mreg[3]);
      check("reset_mem0", ram_word(0), mword(0));
    end
    push_segment(L1);
    rst = 1'b0;
    repeat (L1) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset_pc", tap.pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_all_regs("after_midreset");
    mpc = '0;
    push_segment(L2);
    rst = 1'b0;
    repeat (L2) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'h0);
    check_all_regs("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
